fifo_protocol_checker: RTL and testbench

FIFO_PROTOCOL_CHECKER -- requirements
Module: fifo_protocol_checker

---
 rtl/fifo_chk_pkg.sv | 40 ++++
 rtl/fifo_shadow_queue.sv | 47 ++++
 rtl/fifo_protocol_checker.sv | 196 +++++++++++++++++++
 tb/tb_fifo_protocol_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO protocol checker: FSM states, error-bit
// positions and small helper functions used by the checker top level.
package fifo_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } chk_state_t;

    // Bit positions inside err_flags.
    localparam int ERR_FULL        = 0;
    localparam int ERR_EMPTY       = 1;
    localparam int ERR_ALMOSTFULL  = 2;
    localparam int ERR_ALMOSTEMPTY = 3;
    localparam int ERR_WR_ACK      = 4;
    localparam int ERR_OVERFLOW    = 5;
    localparam int ERR_UNDERFLOW   = 6;
    localparam int ERR_DATA        = 7;
    localparam int ERR_BITS        = 8;

    // Increment that sticks at 2^width-1; counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [32:0] max_val;
        max_val = (33'd1 << width) - 33'd1;
        return ({1'b0, value} == max_val) ? value : value + 32'd1;
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [ERR_BITS-1:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = ERR_BITS - 1; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_shadow_queue.sv
// Shadow copy of the observed FIFO's storage: a circular buffer whose head
// word is what the observed FIFO must return on its next accepted read.
module fifo_shadow_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Pointer update; clear restarts the queue when the checker re-arms.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // Storage write.
    // NOTE: storage is not reset; occupancy and pointers define which words are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_protocol_checker.sv
// Passive checker for a synchronous FIFO: keeps a shadow occupancy and data
// queue, compares the observed status flags and read data against it, counts
// traffic events and latches sticky error flags.
module fifo_protocol_checker
    import fifo_chk_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int AF_LEVEL    = DEPTH - 1,
    parameter int AE_LEVEL    = 1,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         chk_en,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         full,
    input  logic                         empty,
    input  logic                         almostfull,
    input  logic                         almostempty,
    input  logic                         wr_ack,
    input  logic                         overflow,
    input  logic                         underflow,
    output logic [7:0]                   err_flags,
    output logic                         err_valid,
    output logic [2:0]                   first_err_code,
    output logic [CNT_W-1:0]             wr_count,
    output logic [CNT_W-1:0]             rd_count,
    output logic [CNT_W-1:0]             ovf_count,
    output logic [CNT_W-1:0]             udf_count,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [1:0]                   state
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    chk_state_t            state_q;
    chk_state_t            state_d;
    logic [OCC_W-1:0]      occ;
    logic                  in_check;
    logic                  shadow_full;
    logic                  shadow_empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ERR_BITS-1:0]   err_now;
    logic                  new_err;

    // Outcome of the previous CHECK cycle, compared against this cycle's
    // wr_ack/overflow/underflow/data_out.
    logic                  pend_valid;
    logic                  pend_wr_acc;
    logic                  pend_ovf;
    logic                  pend_udf;
    logic                  pend_rd_acc;
    logic [DATA_WIDTH-1:0] pend_data;

    assign in_check     = (state_q == ST_CHECK);
    assign shadow_full  = (occ == OCC_W'(DEPTH));
    assign shadow_empty = (occ == '0);
    // Acceptance follows the shadow model, so both are taken when 0<occ<DEPTH.
    assign wr_acc       = wr_en && !shadow_full;
    assign rd_acc       = rd_en && !shadow_empty;
    assign push         = in_check && wr_acc;
    assign pop          = in_check && rd_acc;

    fifo_shadow_queue #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_shadow_queue (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == ST_ARMED),
        .push     (push),
        .pop      (pop),
        .push_data(data_in),
        .head_data(head_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; chk_en=0 always returns to IDLE, clr releases HALT.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (chk_en) state_d = ST_ARMED;
            ST_ARMED: state_d = chk_en ? ST_CHECK : ST_IDLE;
            ST_CHECK: begin
                if (!chk_en)                                 state_d = ST_IDLE;
                else if (!clr && STOP_ON_ERR != 0 && new_err) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!chk_en)  state_d = ST_IDLE;
                else if (clr) state_d = ST_CHECK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-cycle error detection: flag checks plus last cycle's outcome checks.
    always_comb begin
        err_now = '0;
        if (in_check) begin
            err_now[ERR_FULL]        = (full        != shadow_full);
            err_now[ERR_EMPTY]       = (empty       != shadow_empty);
            err_now[ERR_ALMOSTFULL]  = (almostfull  != (occ == OCC_W'(AF_LEVEL)));
            err_now[ERR_ALMOSTEMPTY] = (almostempty != (occ == OCC_W'(AE_LEVEL)));
            if (pend_valid) begin
                err_now[ERR_WR_ACK]    = (wr_ack    != pend_wr_acc);
                err_now[ERR_OVERFLOW]  = (overflow  != pend_ovf);
                err_now[ERR_UNDERFLOW] = (underflow != pend_udf);
                err_now[ERR_DATA]      = pend_rd_acc && (data_out != pend_data);
            end
        end
        if (state_q == ST_ARMED) begin
            err_now[ERR_EMPTY] = !empty;
        end
    end

    assign new_err = |err_now;

    // Capture this cycle's outcome for checking on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_wr_acc <= 1'b0;
            pend_ovf    <= 1'b0;
            pend_udf    <= 1'b0;
            pend_rd_acc <= 1'b0;
            pend_data   <= '0;
        end else begin
            pend_valid  <= in_check;
            pend_wr_acc <= wr_acc;
            pend_ovf    <= wr_en && shadow_full;
            pend_udf    <= rd_en && shadow_empty;
            pend_rd_acc <= rd_acc;
            pend_data   <= head_data;
        end
    end

    // Shadow occupancy: cleared on arming, tracks traffic only while checking.
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_ARMED) begin
            occ <= '0;
        end else if (in_check) begin
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Saturating event counters; clr has priority over same-cycle events.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_count  <= '0;
            rd_count  <= '0;
            ovf_count <= '0;
            udf_count <= '0;
        end else if (in_check) begin
            if (wr_acc)                 wr_count  <= CNT_W'(sat_inc(32'(wr_count), CNT_W));
            if (rd_acc)                 rd_count  <= CNT_W'(sat_inc(32'(rd_count), CNT_W));
            if (wr_en && shadow_full)   ovf_count <= CNT_W'(sat_inc(32'(ovf_count), CNT_W));
            if (rd_en && shadow_empty)  udf_count <= CNT_W'(sat_inc(32'(udf_count), CNT_W));
        end
    end

    // Sticky error flags; the first erroring cycle's lowest bit is recorded.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_flags      <= '0;
            first_err_code <= '0;
        end else if (new_err) begin
            err_flags <= err_flags | err_now;
            if (!err_valid) first_err_code <= lowest_set(err_now);
        end
    end

    assign err_valid = |err_flags;
    assign occupancy = occ;
    assign state     = state_q;

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Bench for fifo_protocol_checker: a behavioural model of a correct FIFO
// drives the observed signals, with hooks to corrupt data or a flag.
module tb_fifo_protocol_checker;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst, chk_en, clr, wr_en, rd_en;
    logic [DW-1:0] data_in, data_out;
    logic          full, empty, almostfull, almostempty;
    logic          wr_ack, overflow, underflow;
    logic [7:0]    err_flags;
    logic          err_valid;
    logic [2:0]    first_err_code;
    logic [CW-1:0] wr_count, rd_count, ovf_count, udf_count;
    logic [3:0]    occupancy;
    logic [1:0]    state;

    fifo_protocol_checker #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_W      (CW),
        .STOP_ON_ERR(1)
    ) dut (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr(clr),
        .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .err_flags(err_flags), .err_valid(err_valid), .first_err_code(first_err_code),
        .wr_count(wr_count), .rd_count(rd_count), .ovf_count(ovf_count), .udf_count(udf_count),
        .occupancy(occupancy), .state(state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Observed FIFO model state and fault hooks.
    logic [DW-1:0] model_q[$];
    logic          nxt_ack, nxt_ovf, nxt_udf;
    logic [DW-1:0] nxt_dout;
    logic          fault_full_low;
    logic          corrupt_next;

    // One clock: drive requests plus the model's status at the falling edge,
    // advance the model, then return 1 time unit after the rising edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        int   sz;
        logic wacc, racc;
        @(negedge clk);
        sz          = model_q.size();
        wr_en       = w;
        rd_en       = r;
        data_in     = d;
        clr         = c;
        wr_ack      = nxt_ack;
        overflow    = nxt_ovf;
        underflow   = nxt_udf;
        data_out    = nxt_dout;
        full        = (sz == DEPTH) && !fault_full_low;
        empty       = (sz == 0);
        almostfull  = (sz == DEPTH - 1);
        almostempty = (sz == 1);
        if (rst) begin
            model_q.delete();
            nxt_ack = 1'b0;
            nxt_ovf = 1'b0;
            nxt_udf = 1'b0;
        end else begin
            wacc    = w && (sz != DEPTH);
            racc    = r && (sz != 0);
            nxt_ack = wacc;
            nxt_ovf = w && (sz == DEPTH);
            nxt_udf = r && (sz == 0);
            if (racc) begin
                nxt_dout = model_q.pop_front();
                if (corrupt_next) begin
                    nxt_dout     = 16'hDEAD;
                    corrupt_next = 1'b0;
                end
            end
            if (wacc) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic arm(input string tag);
        chk_en = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        check({tag, "_armed"}, 32'(state), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0);
        check({tag, "_check"}, 32'(state), 32'd2);
    endtask

    // Vector table with scoreboard of expected outputs.
    typedef struct packed {
        logic [3:0]    occ;
        logic [CW-1:0] wr;
        logic [CW-1:0] rd;
        logic [CW-1:0] ovf;
        logic [CW-1:0] udf;
        logic          err;
    } exp_t;

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic [DW-1:0] data;
        logic          clr;
        exp_t          want;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void add_vec(logic w, logic r, logic [DW-1:0] d, logic c,
                                    int occ, int wr, int rd, int ovf, int udf);
        vec_t v;
        v.wr = w; v.rd = r; v.data = d; v.clr = c;
        v.want.occ = 4'(occ);
        v.want.wr  = CW'(wr);
        v.want.rd  = CW'(rd);
        v.want.ovf = CW'(ovf);
        v.want.udf = CW'(udf);
        v.want.err = 1'b0;
        vecs.push_back(v);
    endfunction

    initial begin
        exp_t got;

        // Fill 0x0001..0x0008, overflow, partial drain, clear, 10 simultaneous
        // read/writes at occupancy 4, full drain, underflow.
        for (int i = 0; i < 8; i++) add_vec(1, 0, 16'(i + 1), 0, i + 1, i + 1, 0, 0, 0);
        add_vec(1, 0, 16'h0009, 0, 8, 8, 0, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8, 8, 0, 1, 0);
        for (int i = 0; i < 4; i++) add_vec(0, 1, 16'h0000, 0, 7 - i, 8, i + 1, 1, 0);
        add_vec(0, 0, 16'h0000, 1, 4, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add_vec(1, 1, 16'(16'h0100 + i), 0, 4, i + 1, i + 1, 0, 0);
        add_vec(0, 0, 16'h0000, 0, 4, 10, 10, 0, 0);
        for (int i = 0; i < 4; i++) add_vec(0, 1, 16'h0000, 0, 3 - i, 10, 11 + i, 0, 0);
        add_vec(0, 1, 16'h0000, 0, 0, 10, 14, 0, 1);
        add_vec(0, 0, 16'h0000, 0, 0, 10, 14, 0, 1);

        {rst, chk_en, clr, wr_en, rd_en} = '0;
        {data_in, data_out} = '0;
        {full, empty, almostfull, almostempty, wr_ack, overflow, underflow} = '0;
        {nxt_ack, nxt_ovf, nxt_udf, fault_full_low, corrupt_next} = '0;
        nxt_dout = '0;

        // Reset state.
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_err_flags", 32'(err_flags), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_first_code", 32'(first_err_code), 32'd0);

        arm("main");

        // Table-driven traffic against a correct FIFO.
        for (int i = 0; i < vecs.size(); i++) begin
            sb.push_back(vecs[i].want);
            step(vecs[i].wr, vecs[i].rd, vecs[i].data, vecs[i].clr);
            got = sb.pop_front();
            check($sformatf("v%0d_occ", i), 32'(occupancy), 32'(got.occ));
            check($sformatf("v%0d_wr_count", i), 32'(wr_count), 32'(got.wr));
            check($sformatf("v%0d_rd_count", i), 32'(rd_count), 32'(got.rd));
            check($sformatf("v%0d_ovf_count", i), 32'(ovf_count), 32'(got.ovf));
            check($sformatf("v%0d_udf_count", i), 32'(udf_count), 32'(got.udf));
            check($sformatf("v%0d_err_valid", i), 32'(err_valid), 32'(got.err));
        end
        check("main_err_flags", 32'(err_flags), 32'd0);

        // Corrupted third read word during a drain.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(i + 1), 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        corrupt_next = 1'b1;
        step(1'b0, 1'b1, '0, 1'b0);
        check("data_no_err_yet", 32'(err_valid), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("data_err_flags", 32'(err_flags), 32'h80);
        check("data_first_code", 32'(first_err_code), 32'd7);
        check("data_err_valid", 32'(err_valid), 32'd1);
        check("data_halt", 32'(state), 32'd3);
        step(1'b0, 1'b1, '0, 1'b0);
        check("data_occ_frozen", 32'(occupancy), 32'd5);

        // Full flag forced low at occupancy 8, then recovery by clr.
        do_reset();
        arm("flag");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h0A00 + i), 1'b0);
        check("flag_occ8", 32'(occupancy), 32'd8);
        fault_full_low = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        fault_full_low = 1'b0;
        check("flag_err_flags", 32'(err_flags), 32'h01);
        check("flag_first_code", 32'(first_err_code), 32'd0);
        check("flag_halt", 32'(state), 32'd3);
        step(1'b1, 1'b0, 16'h0BAD, 1'b0);
        step(1'b1, 1'b0, 16'h0BAD, 1'b0);
        check("flag_ovf_frozen", 32'(ovf_count), 32'd0);
        check("flag_wr_frozen", 32'(wr_count), 32'd8);
        check("flag_occ_frozen", 32'(occupancy), 32'd8);
        step(1'b0, 1'b0, '0, 1'b1);
        check("clr_state", 32'(state), 32'd2);
        check("clr_err_valid", 32'(err_valid), 32'd0);
        check("clr_err_flags", 32'(err_flags), 32'd0);
        check("clr_wr_count", 32'(wr_count), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("post_clr_err_valid", 32'(err_valid), 32'd0);
        check("post_clr_state", 32'(state), 32'd2);

        // Reset asserted mid-fill at occupancy 5.
        do_reset();
        arm("midrst");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h0C00 + i), 1'b0);
        check("midrst_occ5", 32'(occupancy), 32'd5);
        rst = 1'b1;
        step(1'b1, 1'b0, 16'h0C05, 1'b0);
        rst = 1'b0;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_occ", 32'(occupancy), 32'd0);
        check("midrst_wr_count", 32'(wr_count), 32'd0);
        check("midrst_rd_count", 32'(rd_count), 32'd0);
        check("midrst_ovf_count", 32'(ovf_count), 32'd0);
        check("midrst_udf_count", 32'(udf_count), 32'd0);
        check("midrst_err_flags", 32'(err_flags), 32'd0);
        check("midrst_err_valid", 32'(err_valid), 32'd0);
        check("midrst_first_code", 32'(first_err_code), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("after_rst_err_valid", 32'(err_valid), 32'd0);
        check("after_rst_armed", 32'(state), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0);
        check("after_rst_err_valid2", 32'(err_valid), 32'd0);

        // Disabling returns to IDLE.
        chk_en = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);
        check("disable_idle", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
